// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg
//   Shared definitions for the ALU issue controller: the opcodes that
//   alu_16b implements, the idle opcode, the controller state encoding
//   and the settle-counter width.
package alu_issue_ctrl_pkg;

  // Opcodes understood by the ALU. Anything else is rejected by the
  // issue controller before it reaches the ALU.
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b1101;

  // Code presented to the ALU while nothing is being executed.
  localparam logic [3:0] ALU_NOP = 4'b0000;

  // Settle counter holds SETTLE_CYCLES-1, with SETTLE_CYCLES in 1..15.
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Bundles the three buses around the issue controller:
//     req_*     decode -> controller request handshake
//     alu_*     controller <-> alu_16b operand/result bus (plus cond_code)
//     rsp_*     controller -> writeback response handshake
//   Modports:
//     slave  : the issue controller (accepts requests, drives the ALU)
//     master : the surrounding environment (decode, ALU, writeback)
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic [WIDTH-1:0] alu_inA;
  logic [WIDTH-1:0] alu_inB;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_out;
  logic [5:0]       cond_code;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [5:0]       rsp_cc;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready,
    output alu_inA, alu_inB, alu_ctrl,
    input  alu_out, cond_code,
    output rsp_valid, rsp_data, rsp_cc, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready,
    input  alu_inA, alu_inB, alu_ctrl,
    output alu_out, cond_code,
    input  rsp_valid, rsp_data, rsp_cc, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Initiator side of the ALU operand/control interface. Takes one
//   operation at a time from decode, drives it into alu_16b, waits
//   SETTLE_CYCLES, captures result and condition code, and hands them to
//   writeback. Undefined opcodes are answered with rsp_err=1 without ever
//   reaching the ALU.
//   Ports:
//     clk       clock, all state changes on the rising edge
//     rst       synchronous active-high reset
//     bus       alu_issue_ctrl_if.slave (req_*, alu_*, cond_code, rsp_*)
//     op_count  number of completed response handshakes (wraps)
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  bus,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_e              state_q,    state_d;
  logic [WIDTH-1:0]    in_a_q,     in_a_d;
  logic [WIDTH-1:0]    in_b_q,     in_b_d;
  logic [3:0]          ctrl_q,     ctrl_d;
  logic [WIDTH-1:0]    data_q,     data_d;
  logic [5:0]          cc_q,       cc_d;
  logic                err_q,      err_d;
  logic [SETTLE_W-1:0] settle_q,   settle_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_a_q     <= '0;
      in_b_q     <= '0;
      ctrl_q     <= ALU_NOP;
      data_q     <= '0;
      cc_q       <= '0;
      err_q      <= 1'b0;
      settle_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
      cc_q       <= cc_d;
      err_q      <= err_d;
      settle_q   <= settle_d;
      op_count_q <= op_count_d;
    end
  end

  // Next-state and datapath updates. Everything holds unless a
  // transition below says otherwise.
  always_comb begin
    state_d    = state_q;
    in_a_d     = in_a_q;
    in_b_d     = in_b_q;
    ctrl_d     = ctrl_q;
    data_d     = data_q;
    cc_d       = cc_q;
    err_d      = err_q;
    settle_d   = settle_q;
    op_count_d = op_count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (op_is_legal(bus.req_op)) begin
            in_a_d   = bus.req_a;
            in_b_d   = bus.req_b;
            ctrl_d   = bus.req_op;
            settle_d = SETTLE_LOAD;
            state_d  = ST_EXEC;
          end else begin
            // Rejected without touching the ALU; operands keep old values.
            ctrl_d  = ALU_NOP;
            data_d  = '0;
            cc_d    = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        if (settle_q != '0) begin
          settle_d = settle_q - SETTLE_W'(1);
        end else begin
          // alu_out/cond_code are only trusted on this capture edge.
          data_d  = bus.alu_out;
          cc_d    = bus.cond_code;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          ctrl_d     = ALU_NOP;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: handshakes decode from state only, so there is no
  // combinational path from req_valid or rsp_ready.
  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_DONE);
    bus.alu_inA   = in_a_q;
    bus.alu_inB   = in_b_q;
    bus.alu_ctrl  = ctrl_q;
    bus.rsp_data  = data_q;
    bus.rsp_cc    = cc_q;
    bus.rsp_err   = err_q;
    op_count      = op_count_q;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//   Self-checking bench for alu_issue_ctrl with SETTLE_CYCLES=3. The bench
//   plays decode, writeback and a stand-in ALU; cond_code is re-randomised
//   every cycle so the captured value pins down the capture edge.
module tb_alu_issue_ctrl;
  localparam int W      = 32;
  localparam int SETTLE = 3;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_count;

  alu_issue_ctrl_if #(.WIDTH(W)) bus ();

  alu_issue_ctrl #(
    .WIDTH(W),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference arithmetic for the six opcodes.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op);
    case (op)
      4'b0001: return a + b;
      4'b1001: return a - b;
      4'b0011: return a & b;
      4'b0100: return a | b;
      4'b0101: return a << b[4:0];
      4'b1101: return a >> b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic bit is_legal_ref(input logic [3:0] op);
    return op inside {4'b0001, 4'b1001, 4'b0011, 4'b0100, 4'b0101, 4'b1101};
  endfunction

  // Stand-in ALU and a condition code that changes every cycle.
  always_comb bus.alu_out = ref_alu(bus.alu_inA, bus.alu_inB, bus.alu_ctrl);
  always @(negedge clk) bus.cond_code = 6'($urandom);

  // One complete transaction: accept, execute, optional back-pressure,
  // response handshake. Called at a negedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                        input int rsp_wait, input bit busy_req, input string tag);
    bit         legal;
    int         lat;
    logic [W-1:0] exp_data;
    logic [5:0] exp_cc;
    logic [5:0] cc_seen;
    logic [3:0] exp_ctrl;
    legal    = is_legal_ref(op);
    lat      = legal ? SETTLE : 0;
    exp_data = legal ? ref_alu(a, b, op) : '0;
    exp_ctrl = legal ? op : 4'b0000;
    cc_seen  = '0;

    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_req_ready: got %b want 1", tag, bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_op = op; bus.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Either drop the request or present a new one that must be ignored.
    bus.req_valid = busy_req;
    if (busy_req) begin
      bus.req_a = $urandom; bus.req_b = $urandom; bus.req_op = 4'b1001;
    end

    for (int d = 0; d <= lat; d++) begin
      if (d > 0) begin
        @(posedge clk);
        cc_seen = bus.cond_code;
        @(negedge clk);
      end
      // rsp_ready is noise while executing.
      bus.rsp_ready = (d < lat) ? 1'($urandom) : 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'(d == lat)) begin
        errors++; $display("FAIL %s rsp_valid_timing d=%0d: got %b want %b", tag, d, bus.rsp_valid, d == lat);
      end
      checks++;
      if (bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL %s busy_req_ready d=%0d: got %b want 0", tag, d, bus.req_ready);
      end
      checks++;
      if (bus.alu_ctrl !== exp_ctrl) begin
        errors++; $display("FAIL %s alu_ctrl d=%0d: got %b want %b", tag, d, bus.alu_ctrl, exp_ctrl);
      end
      if (legal) begin
        checks++;
        if (bus.alu_inA !== a || bus.alu_inB !== b) begin
          errors++; $display("FAIL %s operands d=%0d: got %h/%h want %h/%h", tag, d, bus.alu_inA, bus.alu_inB, a, b);
        end
      end
    end

    exp_cc = legal ? cc_seen : 6'd0;
    checks++;
    if (bus.rsp_data !== exp_data) begin
      errors++; $display("FAIL %s rsp_data: got %h want %h", tag, bus.rsp_data, exp_data);
    end
    checks++;
    if (bus.rsp_cc !== exp_cc) begin
      errors++; $display("FAIL %s rsp_cc: got %h want %h", tag, bus.rsp_cc, exp_cc);
    end
    checks++;
    if (bus.rsp_err !== !legal) begin
      errors++; $display("FAIL %s rsp_err: got %b want %b", tag, bus.rsp_err, !legal);
    end

    for (int w = 0; w < rsp_wait; w++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL %s hold_handshake w=%0d: got v=%b r=%b want v=1 r=0", tag, w, bus.rsp_valid, bus.req_ready);
      end
      checks++;
      if (bus.rsp_data !== exp_data || bus.rsp_cc !== exp_cc || bus.alu_ctrl !== exp_ctrl) begin
        errors++; $display("FAIL %s hold_outputs w=%0d: got %h/%h/%b want %h/%h/%b", tag, w,
                           bus.rsp_data, bus.rsp_cc, bus.alu_ctrl, exp_data, exp_cc, exp_ctrl);
      end
      checks++;
      if (op_count !== exp_count) begin
        errors++; $display("FAIL %s hold_count w=%0d: got %0d want %0d", tag, w, op_count, exp_count);
      end
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_count = exp_count + CNT_W'(1);
    checks++;
    if (op_count !== exp_count) begin
      errors++; $display("FAIL %s op_count: got %0d want %0d", tag, op_count, exp_count);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s post_handshake: got v=%b r=%b want v=0 r=1", tag, bus.rsp_valid, bus.req_ready);
    end
    checks++;
    if (bus.alu_ctrl !== 4'b0000) begin
      errors++; $display("FAIL %s alu_ctrl_idle: got %b want 0000", tag, bus.alu_ctrl);
    end
    if (legal) begin
      checks++;
      if (bus.alu_inA !== a || bus.alu_inB !== b) begin
        errors++; $display("FAIL %s operands_kept: got %h/%h want %h/%h", tag, bus.alu_inA, bus.alu_inB, a, b);
      end
    end
    bus.req_valid = 1'b0;
    $display("txn %s op=%b a=%h b=%h data=%h cc=%h err=%b count=%0d",
             tag, op, a, b, exp_data, exp_cc, !legal, exp_count);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_op = 4'b0001; bus.req_a = 32'h5; bus.req_b = 32'h7;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    exp_count = '0;
    checks++;
    if (bus.alu_inA !== '0 || bus.alu_inB !== '0 || bus.alu_ctrl !== 4'b0000) begin
      errors++; $display("FAIL reset_alu_bus: got %h/%h/%b want 0/0/0", bus.alu_inA, bus.alu_inB, bus.alu_ctrl);
    end
    checks++;
    if (bus.rsp_data !== '0 || bus.rsp_cc !== '0 || bus.rsp_err !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: got d=%h cc=%h e=%b v=%b want all 0", bus.rsp_data, bus.rsp_cc, bus.rsp_err, bus.rsp_valid);
    end
    checks++;
    if (op_count !== '0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_count_ready: got cnt=%0d r=%b want 0/1", op_count, bus.req_ready);
    end
    $display("txn reset done");
  endtask

  task automatic test_legal_ops();
    logic [3:0] ops [6];
    ops = '{4'b0001, 4'b1001, 4'b0011, 4'b0100, 4'b0101, 4'b1101};
    foreach (ops[i]) run_op(32'h10, 32'h2, ops[i], 0, 1'b0, "legal");
    checks++;
    if (op_count !== 16'd6) begin
      errors++; $display("FAIL legal_final_count: got %0d want 6", op_count);
    end
  endtask

  task automatic test_settle_latency();
    run_op(32'h1234_5678, 32'h0000_1111, 4'b0001, 0, 1'b0, "latency");
  endtask

  task automatic test_illegal();
    run_op(32'hAAAA_0000, 32'h5555, 4'b0110, 0, 1'b0, "illegal_0110");
    run_op(32'h0000_00FF, 32'h1, 4'b0000, 1, 1'b0, "illegal_0000");
  endtask

  task automatic test_back_to_back();
    run_op(32'h0000_0F0F, 32'h0000_00F3, 4'b0011, 5, 1'b1, "backpressure");
    run_op(32'h0000_0010, 32'h0000_0003, 4'b0111, 5, 1'b1, "backpressure_err");
  endtask

  task automatic test_reset_mid_exec();
    bus.req_valid = 1'b1; bus.req_a = 32'h10; bus.req_b = 32'h2; bus.req_op = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    checks++;
    if (bus.alu_inA !== '0 || bus.alu_inB !== '0 || bus.alu_ctrl !== 4'b0000 || op_count !== '0) begin
      errors++; $display("FAIL midreset_state: got %h/%h/%b cnt=%0d want 0/0/0 cnt=0",
                         bus.alu_inA, bus.alu_inB, bus.alu_ctrl, op_count);
    end
    for (int k = 0; k < SETTLE + 2; k++) begin
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++; $display("FAIL midreset_no_rsp k=%0d: got v=%b r=%b want v=0 r=1", k, bus.rsp_valid, bus.req_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    run_op(32'h10, 32'h2, 4'b0001, 0, 1'b0, "after_reset");
  endtask

  task automatic test_count_wrap();
    force dut.op_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.op_count_q;
    exp_count = 16'hFFFF;
    checks++;
    if (op_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: got %h want ffff", op_count);
    end
    run_op(32'h10, 32'h2, 4'b0001, 0, 1'b0, "wrap");
    checks++;
    if (op_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_value: got %h want 0000", op_count);
    end
  endtask

  task automatic test_random();
    logic [3:0] ops [6];
    logic [3:0] op;
    ops = '{4'b0001, 4'b1001, 4'b0011, 4'b0100, 4'b0101, 4'b1101};
    for (int n = 0; n < 24; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 5)];
      run_op($urandom, $urandom, op, $urandom_range(0, 3), 1'($urandom), "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b0; bus.cond_code = '0;
    exp_count = '0;
    @(negedge clk);
    test_reset();
    test_legal_ops();
    test_settle_latency();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    test_count_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
